// File: rtl/decodificador_saltos.sv
// Branch decoder: splits fetch words into fields, redirects fetch on taken branches and squashes the wrong path.
// Latency: one clk from Instruccion to registered fields and redirect; the wrong-path squash follows for FLUSH_CYCLES clk.
// Backpressure: none; a new word is accepted every clk, and Done parks the block in HALTED until it drops.
module decodificador_saltos #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instruccion,
    input  logic        Done,
    input  logic        zero_flag,
    output logic [6:0]  branchResultOut,
    output logic        instr_valid,
    output logic [4:0]  op_out,
    output logic [4:0]  rd_out,
    output logic [4:0]  rs_out,
    output logic [4:0]  rt_out,
    output logic [15:0] imm_out,
    output logic        branch_err,
    output logic [15:0] branch_count
);

    typedef enum logic [1:0] {
        START  = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [4:0]  OP_JMP    = 5'b01000;
    localparam logic [4:0]  OP_BEQ    = 5'b01001;
    localparam logic [4:0]  OP_BNE    = 5'b01010;
    localparam logic [15:0] COUNT_MAX = 16'hFFFF;
    localparam logic [1:0]  FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [1:0] flush_left;

    logic [4:0] word_op;
    logic [6:0] word_target;
    logic       branch_taken;

    // Decode the branch condition of the incoming word; only consulted while in RUN.
    always_comb begin
        word_op      = Instruccion[31:27];
        word_target  = Instruccion[6:0];
        branch_taken = 1'b0;
        case (word_op)
            OP_JMP:  branch_taken = 1'b1;
            OP_BEQ:  branch_taken = zero_flag;
            OP_BNE:  branch_taken = ~zero_flag;
            default: branch_taken = 1'b0;
        endcase
    end

    // Control FSM with registered outputs; redirect and error are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= START;
            flush_left      <= 2'd0;
            branchResultOut <= 7'd0;
            instr_valid     <= 1'b0;
            op_out          <= 5'd0;
            rd_out          <= 5'd0;
            rs_out          <= 5'd0;
            rt_out          <= 5'd0;
            imm_out         <= 16'd0;
            branch_err      <= 1'b0;
            branch_count    <= 16'd0;
        end else begin
            branchResultOut <= 7'd0;
            branch_err      <= 1'b0;
            instr_valid     <= 1'b0;
            case (state)
                // Fetch data is not trusted yet; fields stay untouched so X cannot leak out.
                START: begin
                    state <= RUN;
                end
                RUN: begin
                    if (Done) begin
                        // Halt wins over any branch in the same word.
                        state <= HALTED;
                    end else begin
                        op_out      <= Instruccion[31:27];
                        rd_out      <= Instruccion[26:22];
                        rs_out      <= Instruccion[21:17];
                        rt_out      <= Instruccion[16:12];
                        imm_out     <= Instruccion[15:0];
                        instr_valid <= 1'b1;
                        if (branch_taken) begin
                            if (word_target != 7'd0) begin
                                branchResultOut <= word_target;
                                if (branch_count != COUNT_MAX) begin
                                    branch_count <= branch_count + 16'd1;
                                end
                                flush_left <= FLUSH_RELOAD;
                                state      <= FLUSH;
                            end else begin
                                // Redirect to address 0 is treated as a bad target, not a jump.
                                branch_err <= 1'b1;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Wrong-path words are dropped without looking at them.
                    if (Done) begin
                        state <= HALTED;
                    end else if (flush_left == 2'd0) begin
                        state <= RUN;
                    end else begin
                        flush_left <= flush_left - 2'd1;
                    end
                end
                HALTED: begin
                    if (!Done) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

endmodule
